// File: rtl/noc_input_switch_pkg.sv
// Shared constants and types for the NoC input switch: port indices,
// flit control bit positions, header coordinate layout and input-state enum.
package noc_input_switch_pkg;

  localparam int NOC_FLIT_WIDTH    = 130;
  localparam int NOC_VC_FIFO_DEPTH = 4;
  localparam int NOC_COORD_W       = 4;
  localparam int NOC_NUM_PORTS     = 5;

  // Output port indices
  localparam int PORT_LOCAL = 0;
  localparam int PORT_EAST  = 1;
  localparam int PORT_WEST  = 2;
  localparam int PORT_NORTH = 3;
  localparam int PORT_SOUTH = 4;

  // Flit control bits; payload occupies [127:0]
  localparam int HDR_BIT  = 129;
  localparam int TAIL_BIT = 128;

  // Header coordinates: Y in the lowest field, X directly above it
  localparam int COORD_Y_LSB = 0;
  localparam int COORD_X_LSB = NOC_COORD_W;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } in_state_e;

endpackage

// File: rtl/noc_input_switch_route_xy.sv
// Dimension-ordered (X first, then Y) route computation. Pure combinational,
// produces a one-hot output port request.
module noc_input_switch_route_xy
  import noc_input_switch_pkg::*;
#(
  parameter int COORD_W = NOC_COORD_W
) (
  input  logic [COORD_W-1:0]       dest_x_i,
  input  logic [COORD_W-1:0]       dest_y_i,
  input  logic [COORD_W-1:0]       router_x_i,
  input  logic [COORD_W-1:0]       router_y_i,
  output logic [NOC_NUM_PORTS-1:0] route_o
);

  // Resolve X offset first; only a matching X column looks at Y
  always_comb begin
    route_o = '0;
    if (dest_x_i > router_x_i)      route_o[PORT_EAST]  = 1'b1;
    else if (dest_x_i < router_x_i) route_o[PORT_WEST]  = 1'b1;
    else if (dest_y_i > router_y_i) route_o[PORT_NORTH] = 1'b1;
    else if (dest_y_i < router_y_i) route_o[PORT_SOUTH] = 1'b1;
    else                            route_o[PORT_LOCAL] = 1'b1;
  end

endmodule

// File: rtl/noc_input_switch.sv
// Router input stage: buffers flits from one upstream link, routes each
// packet by its header and forwards it whole to a single output port.
// Only channel 0 of the link is implemented; the flit bus toward the output
// switches is a single broadcast of the FIFO head.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no packet owned; examine head, latch route or drop stray flit
// ST_ACTIVE | forwarding packet to route_q port until its tail is popped
module noc_input_switch
  import noc_input_switch_pkg::*;
#(
  parameter int FLIT_WIDTH = NOC_FLIT_WIDTH,
  parameter int DEPTH      = NOC_VC_FIFO_DEPTH,
  parameter int COORD_W    = NOC_COORD_W,
  parameter int ROUTER_X   = 0,
  parameter int ROUTER_Y   = 0
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst_n,
  // upstream link
  input  logic                     recv_valid_i,
  input  logic [FLIT_WIDTH-1:0]    recv_flit_i,
  output logic                     recv_ready_o,
  output logic                     recv_vc_ready_o,
  // toward output switches
  output logic [NOC_NUM_PORTS-1:0] send_valid_o,
  input  logic [NOC_NUM_PORTS-1:0] send_ready_i,
  output logic [FLIT_WIDTH-1:0]    send_flit_o,
  // allocator request and error pulse
  output logic [NOC_NUM_PORTS-1:0] o_route_req,
  output logic                     o_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [FLIT_WIDTH-1:0]    mem_q [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  in_state_e                state_q;
  logic [NOC_NUM_PORTS-1:0] route_q;
  logic                     err_q;

  logic [FLIT_WIDTH-1:0]    head;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     pop_fwd;
  logic                     pop_drop;
  logic [NOC_NUM_PORTS-1:0] route_w;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);

  // Ready flags are held low for the whole time reset is asserted
  assign recv_ready_o    = noc_rst_n & (count_q != CW'(DEPTH));
  assign recv_vc_ready_o = noc_rst_n & (count_q < CW'(DEPTH - 1));
  assign push            = recv_valid_i & recv_ready_o;

  // route_q is only non-zero while ACTIVE, so it doubles as the valid mask
  assign send_valid_o = route_q & {NOC_NUM_PORTS{~empty}};
  assign send_flit_o  = head;
  assign o_route_req  = route_q;
  assign o_err        = err_q;

  assign pop_fwd  = |(send_valid_o & send_ready_i);
  assign pop_drop = (state_q == ST_IDLE) & ~empty & ~head[HDR_BIT];
  assign pop      = pop_fwd | pop_drop;

  noc_input_switch_route_xy #(
    .COORD_W (COORD_W)
  ) u_route_xy (
    .dest_x_i   (head[2*COORD_W-1:COORD_W]),
    .dest_y_i   (head[COORD_W-1:0]),
    .router_x_i (COORD_W'(ROUTER_X)),
    .router_y_i (COORD_W'(ROUTER_Y)),
    .route_o    (route_w)
  );

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge noc_clk) begin
    if (push) mem_q[wr_ptr_q] <= recv_flit_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet FSM with registered route request and error pulse
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= ST_IDLE;
      route_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            if (head[HDR_BIT]) begin
              route_q <= route_w;
              state_q <= ST_ACTIVE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (pop_fwd && head[TAIL_BIT]) begin
            route_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          route_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_switch.sv
// Self-checking bench for noc_input_switch (router at (1,1), FIFO depth 4).
module tb_noc_input_switch;
  import noc_input_switch_pkg::*;

  localparam int FW    = 130;
  localparam int DEPTH = 4;
  localparam int CWD   = 4;
  localparam int RX    = 1;
  localparam int RY    = 1;

  logic           noc_clk = 1'b0;
  logic           noc_rst_n = 1'b0;
  logic           recv_valid;
  logic [FW-1:0]  recv_flit;
  logic           recv_ready;
  logic           recv_vc_ready;
  logic [4:0]     send_valid;
  logic [4:0]     send_ready;
  logic [FW-1:0]  send_flit;
  logic [4:0]     route_req;
  logic           err;

  int checks = 0;
  int failures = 0;

  always #5 noc_clk = ~noc_clk;

  noc_input_switch #(
    .FLIT_WIDTH (FW),
    .DEPTH      (DEPTH),
    .COORD_W    (CWD),
    .ROUTER_X   (RX),
    .ROUTER_Y   (RY)
  ) dut (
    .noc_clk         (noc_clk),
    .noc_rst_n       (noc_rst_n),
    .recv_valid_i    (recv_valid),
    .recv_flit_i     (recv_flit),
    .recv_ready_o    (recv_ready),
    .recv_vc_ready_o (recv_vc_ready),
    .send_valid_o    (send_valid),
    .send_ready_i    (send_ready),
    .send_flit_o     (send_flit),
    .o_route_req     (route_req),
    .o_err           (err)
  );

  // ---------------- monitor: records output handshakes and protocol breaks
  logic [FW-1:0] mon_flit_q [$];
  int            mon_port_q [$];
  int            mon_err_cnt = 0;
  int            mon_bad_cnt = 0;
  int            mon_valid_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [4:0]    prev_valid;
  logic [FW-1:0] prev_flit;

  always @(negedge noc_clk) begin
    if (!noc_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (send_valid !== prev_valid || send_flit !== prev_flit)) mon_bad_cnt++;
      if ($countones(send_valid) > 1 || (send_valid & ~route_req) != 5'd0) mon_bad_cnt++;
      if (send_valid != 5'd0) mon_valid_cnt++;
      if (err) mon_err_cnt++;
      for (int k = 0; k < 5; k++) begin
        if (send_valid[k] && send_ready[k]) begin
          mon_flit_q.push_back(send_flit);
          mon_port_q.push_back(k);
        end
      end
      prev_valid = send_valid;
      prev_flit  = send_flit;
      prev_stall = (send_valid != 5'd0) && ((send_valid & send_ready) == 5'd0);
    end
  end

  // ---------------- reference model helpers
  function automatic logic [FW-1:0] mk_flit(input bit h, input bit t, input int x, input int y);
    logic [FW-1:0] f;
    f = {$urandom, $urandom, $urandom, $urandom, 2'b00};
    f[129] = h;
    f[128] = t;
    f[7:4] = 4'(x);
    f[3:0] = 4'(y);
    return f;
  endfunction

  // X resolved first, then Y; equal coordinates stay local
  function automatic int exp_port(input int x, input int y);
    if (x > RX) return 1;
    if (x < RX) return 2;
    if (y > RY) return 3;
    if (y < RY) return 4;
    return 0;
  endfunction

  logic [FW-1:0] tx_q [$];

  // Drive tx_q onto the link; returns 1 when everything was accepted in budget
  task automatic stream(input int budget, input bit rnd_valid, input bit rnd_ready, output bit ok);
    int cyc = 0;
    while (tx_q.size() > 0 && cyc < budget) begin
      @(posedge noc_clk); #1;
      if (rnd_ready) send_ready = 5'($urandom);
      recv_valid = !rnd_valid || ($urandom_range(0, 3) != 0);
      recv_flit  = tx_q[0];
      @(negedge noc_clk);
      if (recv_valid && recv_ready) void'(tx_q.pop_front());
      cyc++;
    end
    @(posedge noc_clk); #1;
    recv_valid = 1'b0;
    ok = (tx_q.size() == 0);
  endtask

  task automatic wait_drain(input int n, input int budget, output bit ok);
    int cyc = 0;
    while (mon_flit_q.size() < n && cyc < budget) begin
      @(posedge noc_clk);
      cyc++;
    end
    @(posedge noc_clk); #1;
    ok = (mon_flit_q.size() >= n);
  endtask

  task automatic clear_mon;
    mon_flit_q.delete();
    mon_port_q.delete();
  endtask

  // ---------------- tests
  task automatic test_reset;
    #3;
    checks++; if (recv_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%b exp=0", recv_ready); end
    checks++; if (recv_vc_ready !== 1'b0) begin failures++; $display("FAIL reset_vc_ready_low got=%b exp=0", recv_vc_ready); end
    checks++; if (send_valid !== 5'b0 || route_req !== 5'b0 || err !== 1'b0) begin
      failures++; $display("FAIL reset_outputs valid=%b req=%b err=%b exp=0", send_valid, route_req, err); end
    @(posedge noc_clk); #1;
    @(posedge noc_clk); #1;
    noc_rst_n = 1'b1;
    #1;
    checks++; if (recv_ready !== 1'b1 || recv_vc_ready !== 1'b1) begin
      failures++; $display("FAIL release_ready got=%b/%b exp=1/1", recv_ready, recv_vc_ready); end
    checks++; if (send_valid !== 5'b0 || route_req !== 5'b0) begin
      failures++; $display("FAIL release_outputs valid=%b req=%b exp=0", send_valid, route_req); end
  endtask

  task automatic test_three_flit;
    logic [FW-1:0] h, b, t;
    h = mk_flit(1, 0, 2, 1);
    b = mk_flit(0, 0, 7, 7);
    t = mk_flit(0, 1, 0, 0);
    send_ready = 5'b11111;
    @(posedge noc_clk); #1; recv_valid = 1'b1; recv_flit = h;
    @(posedge noc_clk); #1; recv_flit = b;
    @(negedge noc_clk);
    checks++; if (send_valid !== 5'b0 || route_req !== 5'b0) begin
      failures++; $display("FAIL three_no_early_valid valid=%b req=%b exp=0", send_valid, route_req); end
    @(posedge noc_clk); #1; recv_flit = t;
    @(negedge noc_clk);
    checks++; if (route_req !== 5'b00010 || send_valid !== 5'b00010 || send_flit !== h) begin
      failures++; $display("FAIL three_header req=%b valid=%b flit=%h exp req/valid=00010 flit=%h", route_req, send_valid, send_flit, h); end
    @(posedge noc_clk); #1; recv_valid = 1'b0;
    @(negedge noc_clk);
    checks++; if (send_valid !== 5'b00010 || send_flit !== b) begin
      failures++; $display("FAIL three_body valid=%b flit=%h exp 00010 %h", send_valid, send_flit, b); end
    @(posedge noc_clk); #1;
    @(negedge noc_clk);
    checks++; if (send_valid !== 5'b00010 || send_flit !== t || route_req !== 5'b00010) begin
      failures++; $display("FAIL three_tail valid=%b req=%b flit=%h exp 00010 %h", send_valid, route_req, send_flit, t); end
    @(posedge noc_clk); #1;
    @(negedge noc_clk);
    checks++; if (send_valid !== 5'b0 || route_req !== 5'b0) begin
      failures++; $display("FAIL three_back_idle valid=%b req=%b exp=0", send_valid, route_req); end
  endtask

  task automatic test_single_flits;
    logic [FW-1:0] s1, s2;
    s1 = mk_flit(1, 1, 1, 1);
    s2 = mk_flit(1, 1, 1, 0);
    @(posedge noc_clk); #1; recv_valid = 1'b1; recv_flit = s1;
    @(posedge noc_clk); #1; recv_flit = s2;
    @(posedge noc_clk); #1; recv_valid = 1'b0;
    @(negedge noc_clk);
    checks++; if (route_req !== 5'b00001 || send_valid !== 5'b00001 || send_flit !== s1) begin
      failures++; $display("FAIL single_local req=%b valid=%b exp 00001", route_req, send_valid); end
    @(posedge noc_clk); #1;
    @(negedge noc_clk);
    checks++; if (route_req !== 5'b0 || send_valid !== 5'b0) begin
      failures++; $display("FAIL single_dead_cycle req=%b valid=%b exp=0", route_req, send_valid); end
    @(posedge noc_clk); #1;
    @(negedge noc_clk);
    checks++; if (route_req !== 5'b10000 || send_valid !== 5'b10000 || send_flit !== s2) begin
      failures++; $display("FAIL single_south req=%b valid=%b exp 10000", route_req, send_valid); end
    @(posedge noc_clk); #1;
    @(negedge noc_clk);
    checks++; if (route_req !== 5'b0) begin
      failures++; $display("FAIL single_end_idle req=%b exp=0", route_req); end
  endtask

  task automatic test_backpressure;
    logic [FW-1:0] pkt [7];
    int idx = 0;
    int bad0;
    bit ok;
    clear_mon();
    bad0 = mon_bad_cnt;
    pkt[0] = mk_flit(1, 0, 1, 3);
    for (int i = 1; i < 6; i++) pkt[i] = mk_flit(0, 0, $urandom_range(0, 15), $urandom_range(0, 15));
    pkt[6] = mk_flit(0, 1, 0, 0);
    send_ready = 5'b10111;
    for (int c = 0; c < 8; c++) begin
      @(posedge noc_clk); #1;
      recv_valid = 1'b1; recv_flit = pkt[idx];
      @(negedge noc_clk);
      checks++; if (recv_ready !== (idx < DEPTH)) begin
        failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, recv_ready, idx < DEPTH); end
      checks++; if (recv_vc_ready !== (idx < DEPTH - 1)) begin
        failures++; $display("FAIL bp_vc_ready cyc=%0d got=%b exp=%b", c, recv_vc_ready, idx < DEPTH - 1); end
      if (c >= 3) begin
        checks++; if (send_valid !== 5'b01000 || send_flit !== pkt[0]) begin
          failures++; $display("FAIL bp_hold cyc=%0d valid=%b exp=01000", c, send_valid); end
      end
      if (recv_valid && recv_ready) idx++;
    end
    send_ready = 5'b11111;
    for (int c = 0; c < 40 && idx < 7; c++) begin
      @(posedge noc_clk); #1;
      recv_valid = 1'b1; recv_flit = pkt[idx];
      @(negedge noc_clk);
      if (recv_valid && recv_ready) idx++;
    end
    @(posedge noc_clk); #1; recv_valid = 1'b0;
    checks++; if (idx != 7) begin failures++; $display("FAIL bp_push_timeout pushed=%0d exp=7", idx); end
    wait_drain(7, 60, ok);
    checks++; if (!ok || mon_flit_q.size() != 7) begin
      failures++; $display("FAIL bp_count got=%0d exp=7", mon_flit_q.size()); end
    for (int i = 0; i < 7 && i < mon_flit_q.size(); i++) begin
      checks++; if (mon_flit_q[i] !== pkt[i] || mon_port_q[i] != 3) begin
        failures++; $display("FAIL bp_flit idx=%0d port=%0d exp port=3 flit mismatch=%b", i, mon_port_q[i], mon_flit_q[i] !== pkt[i]); end
    end
    checks++; if (mon_bad_cnt != bad0) begin
      failures++; $display("FAIL bp_protocol violations=%0d exp=0", mon_bad_cnt - bad0); end
  endtask

  task automatic test_body_first;
    int e0, v0;
    clear_mon();
    e0 = mon_err_cnt;
    v0 = mon_valid_cnt;
    send_ready = 5'b11111;
    @(posedge noc_clk); #1; recv_valid = 1'b1; recv_flit = mk_flit(0, 0, 3, 3);
    @(posedge noc_clk); #1; recv_valid = 1'b0;
    repeat (5) @(posedge noc_clk);
    #1;
    checks++; if (mon_err_cnt - e0 != 1) begin
      failures++; $display("FAIL body_first_err pulses=%0d exp=1", mon_err_cnt - e0); end
    checks++; if (mon_valid_cnt != v0 || mon_flit_q.size() != 0) begin
      failures++; $display("FAIL body_first_valid valid_cycles=%0d exp=0", mon_valid_cnt - v0); end
    checks++; if (recv_vc_ready !== 1'b1 || route_req !== 5'b0) begin
      failures++; $display("FAIL body_first_dropped vc_ready=%b req=%b exp 1/0", recv_vc_ready, route_req); end
  endtask

  task automatic test_reset_mid_packet;
    logic [FW-1:0] pkt [4];
    logic [FW-1:0] nh;
    int idx = 0;
    int fwd = 0;
    int v0;
    bit ok;
    pkt[0] = mk_flit(1, 0, 0, 1);
    pkt[1] = mk_flit(0, 0, 5, 5);
    pkt[2] = mk_flit(0, 0, 6, 6);
    pkt[3] = mk_flit(0, 1, 7, 7);
    send_ready = 5'b11111;
    for (int c = 0; c < 40 && fwd < 2; c++) begin
      @(posedge noc_clk); #1;
      recv_valid = (idx < 4); recv_flit = pkt[idx < 4 ? idx : 0];
      @(negedge noc_clk);
      if (recv_valid && recv_ready) idx++;
      if (send_valid[2] && send_ready[2]) fwd++;
    end
    checks++; if (fwd != 2) begin failures++; $display("FAIL rst_mid_forward got=%0d exp=2", fwd); end
    @(posedge noc_clk); #1;
    noc_rst_n = 1'b0; recv_valid = 1'b0;
    #2;
    checks++; if (recv_ready !== 1'b0 || recv_vc_ready !== 1'b0 || send_valid !== 5'b0 || route_req !== 5'b0 || err !== 1'b0) begin
      failures++; $display("FAIL rst_mid_outputs rdy=%b vc=%b valid=%b req=%b err=%b exp all 0", recv_ready, recv_vc_ready, send_valid, route_req, err); end
    @(posedge noc_clk); #1;
    noc_rst_n = 1'b1;
    clear_mon();
    v0 = mon_valid_cnt;
    repeat (4) @(posedge noc_clk);
    #1;
    checks++; if (mon_valid_cnt != v0 || route_req !== 5'b0) begin
      failures++; $display("FAIL rst_mid_no_partial valid_cycles=%0d req=%b exp 0", mon_valid_cnt - v0, route_req); end
    nh = mk_flit(1, 1, 3, 2);
    tx_q.push_back(nh);
    stream(20, 0, 0, ok);
    wait_drain(1, 20, ok);
    checks++; if (!ok || mon_flit_q.size() != 1 || mon_flit_q[0] !== nh || mon_port_q[0] != 1) begin
      failures++; $display("FAIL rst_mid_new_header count=%0d port=%0d exp 1 port=1", mon_flit_q.size(), (mon_port_q.size() > 0) ? mon_port_q[0] : -1); end
  endtask

  task automatic test_random_traffic;
    logic [FW-1:0] exp_flit [$];
    int            exp_pt [$];
    int bad0, len, x, y, p;
    bit ok;
    clear_mon();
    bad0 = mon_bad_cnt;
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(1, 4);
      x = $urandom_range(0, 3);
      y = $urandom_range(0, 3);
      p = exp_port(x, y);
      for (int i = 0; i < len; i++) begin
        logic [FW-1:0] f;
        if (i == 0) f = mk_flit(1, len == 1, x, y);
        else        f = mk_flit(0, i == len - 1, $urandom_range(0, 15), $urandom_range(0, 15));
        tx_q.push_back(f);
        exp_flit.push_back(f);
        exp_pt.push_back(p);
      end
    end
    stream(3000, 1, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_push_timeout left=%0d exp=0", tx_q.size()); tx_q.delete(); end
    send_ready = 5'b11111;
    wait_drain(exp_flit.size(), 200, ok);
    checks++; if (mon_flit_q.size() != exp_flit.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", mon_flit_q.size(), exp_flit.size()); end
    for (int i = 0; i < exp_flit.size() && i < mon_flit_q.size(); i++) begin
      checks++; if (mon_flit_q[i] !== exp_flit[i] || mon_port_q[i] != exp_pt[i]) begin
        failures++; $display("FAIL rand_flit idx=%0d port=%0d exp_port=%0d flit_diff=%b", i, mon_port_q[i], exp_pt[i], mon_flit_q[i] !== exp_flit[i]); end
    end
    checks++; if (mon_bad_cnt != bad0) begin
      failures++; $display("FAIL rand_protocol violations=%0d exp=0", mon_bad_cnt - bad0); end
  endtask

  initial begin
    recv_valid = 1'b0;
    recv_flit  = '0;
    send_ready = 5'b11111;
    test_reset();
    test_three_flit();
    test_single_flits();
    test_backpressure();
    test_body_first();
    test_reset_mid_packet();
    test_random_traffic();
    repeat (2) @(posedge noc_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
